// File: rtl/stump_mem_interface.sv
// rtl/stump_mem_interface.sv - Stump bus adapter: one registered req/ack transaction per access, with stall and watchdog
module stump_mem_interface #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] ir,
    output logic [15:0] ldata,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_FETCH = 2'd0,
        K_READ  = 2'd1,
        K_WRITE = 2'd2
    } kind_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ldata_q, ldata_d;

    logic access;
    assign access = fetch | mem_ren | mem_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_FETCH;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ir_q    <= 16'h0000;
            ldata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            ldata_q <= ldata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        ldata_d = ldata_q;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    // Fixed priority: fetch beats store beats load
                    if (fetch) begin
                        kind_d = K_FETCH;
                        we_d   = 1'b0;
                    end else if (mem_wen) begin
                        kind_d = K_WRITE;
                        we_d   = 1'b1;
                    end else begin
                        kind_d = K_READ;
                        we_d   = 1'b0;
                    end
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final watchdog cycle still completes normally
                if (mem_ack) begin
                    case (kind_q)
                        K_FETCH: ir_d    = mem_rdata;
                        K_READ:  ldata_d = mem_rdata;
                        default: ;
                    endcase
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign stall     = ((state_q == S_IDLE) & access) | (state_q == S_REQ) | (state_q == S_ERR);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ir        = ir_q;
    assign ldata     = ldata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_stump_mem_interface.sv
// tb/tb_stump_mem_interface.sv - self-checking bench for stump_mem_interface
module tb_stump_mem_interface;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, mem_ren, mem_wen, mem_ack;
    logic [15:0] addr, wdata, mem_rdata;
    logic        mem_req, mem_we, stall, bus_err;
    logic [15:0] mem_addr, mem_wdata, ir, ldata;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_ir, exp_ldata;

    stump_mem_interface #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .addr(addr), .wdata(wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ir(ir), .ldata(ldata), .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_req"}, 16'(mem_req), 16'd0);
        check({tag, "_we"}, 16'(mem_we), 16'd0);
        check({tag, "_addr"}, mem_addr, 16'h0000);
        check({tag, "_wdata"}, mem_wdata, 16'h0000);
        check({tag, "_ir"}, ir, 16'h0000);
        check({tag, "_ldata"}, ldata, 16'h0000);
        check({tag, "_err"}, 16'(bus_err), 16'd0);
    endtask

    // Called at a falling edge with the DUT idle; waits >= TO means memory never acks in time.
    task automatic do_access(input bit f, input bit r, input bit w,
                             input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] rd, input int waits);
        bit is_wr;
        is_wr = !f && w;
        fetch = f; mem_ren = r; mem_wen = w; addr = a; wdata = wd;
        #1 check("stall_launch", 16'(stall), 16'd1);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < TO; k++) begin
            check("req_hi", 16'(mem_req), 16'd1);
            check("req_addr", mem_addr, a);
            check("req_we", 16'(mem_we), 16'(is_wr));
            if (is_wr) check("req_wdata", mem_wdata, wd);
            check("req_stall", 16'(stall), 16'd1);
            check("req_err", 16'(bus_err), 16'd0);
            fetch = 1'($urandom); mem_ren = 1'($urandom); mem_wen = 1'($urandom);
            addr = 16'($urandom); wdata = 16'($urandom);
            mem_ack = (k == waits);
            mem_rdata = (k == waits) ? rd : 16'($urandom);
            @(posedge clk); @(negedge clk);
            if (k == waits) break;
        end
        mem_ack = 1'b0; fetch = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        if (waits < TO) begin
            if (f) exp_ir = rd;
            else if (!w) exp_ldata = rd;
            #1;
            check("done_req", 16'(mem_req), 16'd0);
            check("done_we", 16'(mem_we), 16'd0);
            check("done_stall", 16'(stall), 16'd0);
            check("done_ir", ir, exp_ir);
            check("done_ldata", ldata, exp_ldata);
            check("done_err", 16'(bus_err), 16'd0);
            @(posedge clk); @(negedge clk);
            #1;
            check("idle_stall", 16'(stall), 16'd0);
            check("idle_req", 16'(mem_req), 16'd0);
        end else begin
            #1;
            check("to_req", 16'(mem_req), 16'd0);
            check("to_err", 16'(bus_err), 16'd1);
            check("to_stall", 16'(stall), 16'd1);
        end
    endtask

    initial begin
        bit [2:0] s;
        rst = 1'b1; fetch = 0; mem_ren = 0; mem_wen = 0; mem_ack = 0;
        addr = 0; wdata = 0; mem_rdata = 0;
        exp_ir = 16'h0000; exp_ldata = 16'h0000;
        repeat (2) @(negedge clk);
        #1 check_idle_zero("reset");
        check("reset_stall", 16'(stall), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        do_access(1, 0, 0, 16'h0010, 16'h0000, 16'hA5C3, 0);
        do_access(0, 0, 1, 16'h0200, 16'h1234, 16'hDEAD, 2);
        do_access(1, 0, 0, 16'h0020, 16'h0000, 16'h5001, 1);
        do_access(0, 1, 0, 16'h0300, 16'h0000, 16'hBEEF, 0);
        do_access(1, 0, 0, 16'h0040, 16'h0000, 16'h7777, TO - 1);
        do_access(1, 1, 0, 16'h0050, 16'h0000, 16'h1111, 1);
        do_access(0, 1, 1, 16'h0060, 16'h9999, 16'h2222, 0);

        for (int n = 0; n < 40; n++) begin
            do s = 3'($urandom); while (s == 3'b000);
            do_access(s[0], s[1], s[2], 16'($urandom), 16'($urandom), 16'($urandom),
                      int'($urandom_range(0, TO - 1)));
        end

        // Watchdog: never ack, then a late ack must not revive the bus
        do_access(1, 0, 0, 16'h0400, 16'h0000, 16'hFFFF, 99);
        for (int n = 0; n < 3; n++) begin
            mem_ack = 1'b1; mem_rdata = 16'($urandom);
            @(posedge clk); @(negedge clk); #1;
            check("err_req", 16'(mem_req), 16'd0);
            check("err_flag", 16'(bus_err), 16'd1);
            check("err_stall", 16'(stall), 16'd1);
            check("err_ir", ir, exp_ir);
        end
        mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle_zero("err_rst");
        check("err_rst_stall", 16'(stall), 16'd0);
        exp_ir = 16'h0000; exp_ldata = 16'h0000;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Async reset between edges while a request is outstanding
        do_access(1, 0, 0, 16'h0500, 16'h0000, 16'hABCD, 0);
        fetch = 1'b1; addr = 16'h0600;
        @(posedge clk); @(negedge clk);
        #1 check("mid_req_pre", 16'(mem_req), 16'd1);
        #1 rst = 1'b1;
        #1 check_idle_zero("mid_rst");
        fetch = 1'b0;
        #1 check("mid_rst_stall", 16'(stall), 16'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
